// File: rtl/clk_divider_bank_if.sv
// Config write port of clk_divider_bank: a valid/ready handshake that carries
// the target channel and its new half-period.
interface clk_divider_bank_if #(
    parameter int CNT_W = 8,
    parameter int CH_W  = 1
);
    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_ch, output cfg_half, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_half, output cfg_ready);
endinterface

// File: rtl/clk_divider_bank.sv
// Bank of NUM_CH 50%-duty clock dividers off one board clock. Half-periods are
// runtime programmable and change only at a toggle boundary, on disable or on sync.
module clk_divider_bank #(
    parameter int                      NUM_CH    = 2,
    parameter int                      CNT_W     = 8,
    parameter int                      CH_W      = 1,
    parameter logic [NUM_CH*CNT_W-1:0] INIT_HALF = {8'd5, 8'd3}
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_en,
    input  logic              i_sync,
    clk_divider_bank_if.slave cfg,
    output logic [NUM_CH-1:0] o_clk_out,
    output logic [NUM_CH-1:0] o_tick
);

    logic [CNT_W-1:0]  r_cnt       [NUM_CH];
    logic [CNT_W-1:0]  r_half_act  [NUM_CH];
    logic [CNT_W-1:0]  r_half_pend [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_clk_out;
    logic [NUM_CH-1:0] r_tick;

    logic [CNT_W-1:0]  w_h_m1 [NUM_CH];
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_acc;
    logic              w_accept;

    // A single outstanding update across the whole bank keeps the handshake trivial.
    assign cfg.cfg_ready = ~rst && ~|r_pend;
    assign w_accept      = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // A half-period of 0 behaves as 1 (divide by 2).
            w_h_m1[i] = (r_half_act[i] == '0) ? '0 : r_half_act[i] - CNT_W'(1);
            w_wrap[i] = (r_cnt[i] == w_h_m1[i]);
            w_acc[i]  = w_accept && (cfg.cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]       <= '0;
                r_half_act[i]  <= INIT_HALF[i*CNT_W +: CNT_W];
                r_half_pend[i] <= '0;
            end
            r_pend    <= '0;
            r_clk_out <= '0;
            r_tick    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_tick[i] <= 1'b0;
                if (i_sync || !i_en[i]) begin
                    r_cnt[i]     <= '0;
                    r_clk_out[i] <= 1'b0;
                    if (r_pend[i]) begin
                        r_half_act[i] <= r_half_pend[i];
                        r_pend[i]     <= 1'b0;
                    end
                end else if (w_wrap[i]) begin
                    r_cnt[i]     <= '0;
                    r_clk_out[i] <= ~r_clk_out[i];
                    r_tick[i]    <= ~r_clk_out[i];
                    if (r_pend[i]) begin
                        r_half_act[i] <= r_half_pend[i];
                        r_pend[i]     <= 1'b0;
                    end
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
                // Accept only happens with no pend set, so it never races an apply;
                // an accept on a wrap cycle therefore waits for the next wrap.
                if (w_acc[i]) begin
                    r_half_pend[i] <= cfg.cfg_half;
                    r_pend[i]      <= 1'b1;
                end
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule

// File: tb/tb_clk_divider_bank.sv
// Scoreboard bench for clk_divider_bank: stimulus pushes expected tick edges,
// a monitor pops and compares them whenever a watched channel ticks.
module tb_clk_divider_bank;

    logic       clk;
    logic       rst;
    logic [1:0] en;
    logic       sync;
    logic [1:0] clk_out;
    logic [1:0] tick;

    int         edge_n;
    int         checks;
    int         errors;
    logic [1:0] watch;
    logic [1:0] prev_clk;
    int         q0[$];
    int         q1[$];
    int         s;
    int         e;

    clk_divider_bank_if #(.CNT_W(8), .CH_W(2)) cfg_bus ();

    clk_divider_bank #(
        .NUM_CH   (2),
        .CNT_W    (8),
        .CH_W     (2),
        .INIT_HALF({8'd5, 8'd3})
    ) dut (
        .clk_in   (clk),
        .rst      (rst),
        .i_en     (en),
        .i_sync   (sync),
        .cfg      (cfg_bus),
        .o_clk_out(clk_out),
        .o_tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: sample #1 after each rising edge.
    always begin
        @(posedge clk);
        #1;
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("tick_is_rise_ch%0d", i), int'(tick[i]), int'(clk_out[i] & ~prev_clk[i]));
            if (watch[i] && tick[i]) begin
                if (i == 0) begin
                    if (q0.size() == 0) chk("unexpected_tick_ch0", edge_n, -1);
                    else chk("tick_edge_ch0", edge_n, q0.pop_front());
                end else begin
                    if (q1.size() == 0) chk("unexpected_tick_ch1", edge_n, -1);
                    else chk("tick_edge_ch1", edge_n, q1.pop_front());
                end
            end
        end
        prev_clk = clk_out;
    end

    task automatic wait_edge(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    task automatic close_window(input string name);
        if (watch[0]) chk({name, "_missing_ticks_ch0"}, q0.size(), 0);
        if (watch[1]) chk({name, "_missing_ticks_ch1"}, q1.size(), 0);
        watch = 2'b00;
        q0.delete();
        q1.delete();
    endtask

    task automatic do_sync(output int s_edge);
        sync   = 1'b1;
        s_edge = edge_n + 1;
        @(negedge clk);
        sync = 1'b0;
        chk("sync_clk_out_zero", int'(clk_out), 0);
        chk("sync_tick_zero", int'(tick), 0);
    endtask

    task automatic cfg_write(input int ch, input int half);
        int n;
        n = 0;
        while (!cfg_bus.cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_bus.cfg_ready) chk("cfg_ready_timeout", 0, 1);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 2'(ch);
        cfg_bus.cfg_half  = 8'(half);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        edge_n = 0; checks = 0; errors = 0;
        watch = 2'b00; prev_clk = 2'b00;
        rst = 1'b1; en = 2'b00; sync = 1'b0;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_half = '0;

        // Reset defaults: H0=3, H1=5.
        repeat (3) @(negedge clk);
        chk("ready_in_reset", int'(cfg_bus.cfg_ready), 0);
        chk("clk_out_in_reset", int'(clk_out), 0);
        rst = 1'b0; en = 2'b11;
        #1;
        chk("ready_after_reset", int'(cfg_bus.cfg_ready), 1);
        e = edge_n;
        q0.push_back(e + 3); q0.push_back(e + 9); q0.push_back(e + 15);
        q1.push_back(e + 5); q1.push_back(e + 15);
        watch = 2'b11;
        wait_edge(e + 7);
        chk("ch0_low_after_fall", int'(clk_out[0]), 0);
        wait_edge(e + 16);
        close_window("reset_defaults");

        // Sync realigns both channels.
        do_sync(s);
        q0.push_back(s + 3); q1.push_back(s + 5);
        watch = 2'b11;
        wait_edge(s + 6);
        close_window("sync_realign");

        // Glitch-free update: ch0 3 -> 8 written mid-phase.
        do_sync(s);
        q0.push_back(s + 3); q0.push_back(s + 19);
        watch = 2'b01;
        cfg_write(0, 8);
        chk("ready_pending_a", int'(cfg_bus.cfg_ready), 0);
        wait_edge(s + 2);
        chk("ready_pending_b", int'(cfg_bus.cfg_ready), 0);
        wait_edge(s + 3);
        chk("ready_after_apply", int'(cfg_bus.cfg_ready), 1);
        chk("ch0_high_old_phase_end", int'(clk_out[0]), 1);
        wait_edge(s + 10);
        chk("ch0_high_in_8_phase", int'(clk_out[0]), 1);
        wait_edge(s + 11);
        chk("ch0_low_after_8_phase", int'(clk_out[0]), 0);
        wait_edge(s + 20);
        close_window("update_3_to_8");

        // Out-of-range channel write is discarded (ch0 H=8, ch1 H=5 unchanged).
        cfg_write(3, 7);
        chk("ready_after_bad_ch", int'(cfg_bus.cfg_ready), 1);
        do_sync(s);
        q0.push_back(s + 8);
        q1.push_back(s + 5); q1.push_back(s + 15);
        watch = 2'b11;
        wait_edge(s + 16);
        close_window("bad_channel");

        // Accept on ch1's wrap cycle: old H=5 phase completes, H=2 follows.
        do_sync(s);
        q1.push_back(s + 5); q1.push_back(s + 12); q1.push_back(s + 16);
        watch = 2'b10;
        wait_edge(s + 4);
        cfg_write(1, 2);
        chk("ready_coincident_a", int'(cfg_bus.cfg_ready), 0);
        wait_edge(s + 9);
        chk("ready_coincident_b", int'(cfg_bus.cfg_ready), 0);
        chk("ch1_old_phase_full", int'(clk_out[1]), 1);
        wait_edge(s + 10);
        chk("ready_coincident_apply", int'(cfg_bus.cfg_ready), 1);
        chk("ch1_fall_old_phase", int'(clk_out[1]), 0);
        wait_edge(s + 17);
        close_window("coincident_wrap");

        // Half-period 0 on ch0 divides by 2.
        cfg_write(0, 0);
        chk("ready_pending_zero", int'(cfg_bus.cfg_ready), 0);
        do_sync(s);
        chk("ready_after_sync_apply", int'(cfg_bus.cfg_ready), 1);
        q0.push_back(s + 1); q0.push_back(s + 3); q0.push_back(s + 5); q0.push_back(s + 7);
        q1.push_back(s + 2); q1.push_back(s + 6);
        watch = 2'b11;
        wait_edge(s + 8);
        close_window("half_zero");

        // Disable ch1 while high, then re-enable from count 0.
        do_sync(s);
        watch = 2'b10;
        q1.push_back(s + 2);
        wait_edge(s + 2);
        chk("ch1_high_before_disable", int'(clk_out[1]), 1);
        en = 2'b01;
        wait_edge(s + 3);
        chk("ch1_low_after_disable", int'(clk_out[1]), 0);
        wait_edge(s + 9);
        chk("ch1_stays_low", int'(clk_out[1]), 0);
        e = edge_n;
        en = 2'b11;
        q1.push_back(e + 2);
        wait_edge(e + 3);
        close_window("enable_drop");

        // Max half-period 255 on ch1: period 510.
        cfg_write(1, 255);
        chk("ready_pending_255", int'(cfg_bus.cfg_ready), 0);
        do_sync(s);
        q1.push_back(s + 255); q1.push_back(s + 765);
        watch = 2'b10;
        wait_edge(s + 509);
        chk("ch1_high_255", int'(clk_out[1]), 1);
        wait_edge(s + 510);
        chk("ch1_low_510", int'(clk_out[1]), 0);
        wait_edge(s + 766);
        close_window("half_255");

        // Reset mid-operation drops the pending update and restores INIT_HALF.
        cfg_write(1, 9);
        chk("ready_pending_before_rst", int'(cfg_bus.cfg_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("clk_out_after_mid_rst", int'(clk_out), 0);
        chk("ready_during_mid_rst", int'(cfg_bus.cfg_ready), 0);
        rst = 1'b0;
        #1;
        chk("ready_pend_dropped", int'(cfg_bus.cfg_ready), 1);
        e = edge_n;
        q0.push_back(e + 3); q1.push_back(e + 5);
        watch = 2'b11;
        wait_edge(e + 6);
        close_window("mid_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_divider_bank.md
# clk_divider_bank

Parametrised bank of NUM_CH independent 50%-duty clock dividers, all driven from the single board clock. Each channel has a runtime-programmable half-period, an enable, and a one-cycle rising-edge tick. Updates are glitch-free and apply at the channel's next toggle boundary. A global sync realigns all channels to a common phase. The bank replaces fixed two-output dividers and serves VGA pixel-rate, peripheral and debug clock generation in the video pipeline.

## Interface
Parameters:
- NUM_CH, 2: number of divider channels, 1..16.
- CNT_W, 8: width of half-period counters and config value.
- CH_W, 1: width of cfg_ch; must satisfy 2^CH_W >= NUM_CH.
- INIT_HALF, {8'd5, 8'd3}: flattened NUM_CH*CNT_W reset half-periods; channel i occupies bits [i*CNT_W +: CNT_W].

Ports:
- clk_in  input  1  board clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  NUM_CH  per-channel run enable.
- sync  input  1  one-cycle realign request for all channels.
- cfg_valid  input  1  config write request.
- cfg_ch  input  CH_W  target channel.
- cfg_half  input  CNT_W  new half-period, in clk_in cycles.
- cfg_ready  output  1  bank can accept a config write.
- clk_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  one-cycle pulse, high in the cycle clk_out[i] goes 0->1.

## Operation
- Per channel: registers cnt, half_act, half_pend, pend, and clk_out.
- Effective half is H = max(half_act, 1); a value of 0 divides by 2. Output period is 2H clk_in cycles, duty exactly 50%.
- Running (en[i]=1):
  - If cnt == H-1: cnt <= 0 and clk_out toggles. This event is a wrap.
  - Otherwise cnt <= cnt+1.
  - tick[i] <= 1 only when a wrap takes clk_out from 0 to 1; tick is 0 in every other cycle.
- Handshake: a write is accepted when cfg_valid && cfg_ready. On accept, half_pend[cfg_ch] <= cfg_half and pend[cfg_ch] <= 1.
- A write with cfg_ch >= NUM_CH is accepted and discarded.
- cfg_ready = ~rst && ~|pend, combinational. Only one update is outstanding across the bank at a time.
- A pending update applies, with half_act <= half_pend and pend <= 0, on the first of these events:
  - the channel's next wrap, after which the new H governs the following phase;
  - any cycle with en[i]=0;
  - a sync.
- An accept in the same cycle as that channel's wrap does not apply at that wrap. It applies at the following wrap.
- Disabled (en[i]=0): next cycle cnt=0, clk_out=0, tick=0, and the counter holds. When en rises, counting starts from 0, so the first rising edge of clk_out comes H cycles later.
- sync: next cycle, every channel has cnt=0, clk_out=0, tick=0, and all pending updates applied. Enabled channels then run in phase from that point.
- Priority: rst > sync > en=0 > wrap/count. cfg acceptance is independent of sync and en.

## Timing
- Reset values: clk_out=0, tick=0, cnt=0, half_act=INIT_HALF, pend=0. cfg_ready=0 while rst=1 and 1 in the first cycle after.
- After rst falls with en[i]=1, clk_out[i] first rises on rising edge H of clk_in, with tick[i]=1 in that same cycle. It falls at edge 2H, rises again at 3H, and so on.
- clk_out and tick change only on clk_in rising edges, are glitch-free, and have no combinational path from the inputs.
- Config latency: the new H takes effect at the first wrap after the accept, at most H_old cycles later. No output phase is ever shorter than min(H_old, H_new).
- rst mid-operation: all state returns to reset values in the next cycle and pending updates are lost.
- Counter width: cfg_half = 2^CNT_W-1 gives a period of 2*(2^CNT_W-1). cnt never exceeds H-1.

## Test plan
- Reset defaults: rst 3 cycles, then en=2'b11 -> clk_out[0] has period 6 with rises at edges 3, 9, 15; clk_out[1] has period 10 with rises at edges 5, 15; tick one cycle high at each rise; cfg_ready=1 from the first cycle after reset.
- Glitch-free update: channel 0 running with H=3, write cfg_half=8 mid-phase -> the current phase completes at 3 cycles, the next phase lasts 8; cfg_ready is low until the apply and then 1.
- Boundary values: cfg_half=0 -> period 2 (toggle every cycle); cfg_half=255 -> period 510; write cfg_ch=3 with NUM_CH=2 -> accepted, no channel changes, cfg_ready stays 1.
- Accept coincident with a wrap: accept cfg_half=2 in the exact cycle channel 1 wraps -> the old H=5 phase still runs in full, and H=2 applies at the following wrap.
- Enable/sync: drop en[1] while clk_out[1]=1 -> next cycle clk_out[1]=0 and it stays 0; pulse sync with both channels running -> next cycle both are 0, and the rises land at edges +3 and +5 after sync.
- Reset mid-operation with a pending update -> the pending update is dropped, half_act returns to INIT_HALF, and clk_out is 0 in the next cycle.
